// File: rtl/rand_target_pkg.sv
// Shared types and constants for the random target selector.
// The state encoding and default sizing live here so that the top module and
// any consumer of the selector agree on them.
package rand_target_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int TARGETS_DEFAULT = 12;
    localparam int IDX_W_DEFAULT   = 4;
    localparam int TRIES_DEFAULT   = 8;
    localparam int LFSR_W          = 13;

endpackage

// File: rtl/rand_target_accept.sv
// Combinational accept/fallback decision for one rejection-sampling candidate.
// Build option: RAND_TARGET_NO_REPEAT_EN
//   defined   - a candidate equal to the previous target is rejected, and the
//               fallback steps to the next index after the previous target.
//   undefined - only the range check applies; the fallback folds the final
//               out-of-range candidate back into range by subtracting
//               NUM_TARGETS (always fits because 2^IDX_W <= 2*NUM_TARGETS).
module rand_target_accept
    import rand_target_pkg::*;
#(
    parameter int NUM_TARGETS = TARGETS_DEFAULT,
    parameter int IDX_W       = IDX_W_DEFAULT
) (
    input  logic [IDX_W-1:0] cand,
    input  logic [IDX_W-1:0] last,
    input  logic             hist_vld,
    output logic             accept,
    output logic [IDX_W-1:0] fallback
);

    // One extra bit so NUM_TARGETS == 2^IDX_W is representable.
    localparam logic [IDX_W:0] NT = (IDX_W+1)'(NUM_TARGETS);

    logic in_range;
    assign in_range = ({1'b0, cand} < NT);

`ifdef RAND_TARGET_NO_REPEAT_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TARGETS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    assign accept   = in_range && !(hist_vld && (cand == last));
    assign fallback = !hist_vld          ? '0 :
                      (last == LAST_IDX) ? '0 :
                                           (last + ONE);
`else
    // Modular subtraction: only used when cand >= NUM_TARGETS.
    localparam logic [IDX_W-1:0] NT_LO = NT[IDX_W-1:0];

    logic unused_hist;
    assign unused_hist = ^{last, hist_vld};

    assign accept   = in_range;
    assign fallback = cand - NT_LO;
`endif

endmodule

// File: rtl/rand_target_sel.sv
// Bounded random target selector: on request, draws an index in
// 0..NUM_TARGETS-1 from the low bits of a free-running LFSR by rejection
// sampling, gives up after MAX_TRIES draw cycles with a deterministic
// fallback, and holds the result under a valid/ack handshake.
// Build option: RAND_TARGET_NO_REPEAT_EN (resolved in rand_target_accept)
// forbids two consecutive targets from being equal.
module rand_target_sel
    import rand_target_pkg::*;
#(
    parameter int NUM_TARGETS = TARGETS_DEFAULT,
    parameter int IDX_W       = IDX_W_DEFAULT,
    parameter int MAX_TRIES   = TRIES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] random,
    input  logic              req,
    input  logic              ack,
    output logic              busy,
    output logic              valid,
    output logic [IDX_W-1:0]  target
);

    // Wide enough to hold MAX_TRIES-1 with headroom; it stops there, never wraps.
    localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

    state_t           state;
    logic [TRY_W-1:0] tries;
    logic [IDX_W-1:0] last_q;
    logic             hist_vld;

    logic [IDX_W-1:0] cand;
    logic             accept;
    logic [IDX_W-1:0] fallback;

    // Only the low IDX_W bits of the LFSR word drive the draw.
    logic [LFSR_W-IDX_W-1:0] unused_random_hi;
    assign unused_random_hi = random[LFSR_W-1:IDX_W];
    assign cand             = random[IDX_W-1:0];

    rand_target_accept #(
        .NUM_TARGETS (NUM_TARGETS),
        .IDX_W       (IDX_W)
    ) u_accept (
        .cand     (cand),
        .last     (last_q),
        .hist_vld (hist_vld),
        .accept   (accept),
        .fallback (fallback)
    );

    // Control FSM with registered handshake outputs, tries counter and history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tries    <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            target   <= '0;
            last_q   <= '0;
            hist_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= DRAW;
                        tries <= '0;
                        busy  <= 1'b1;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        target   <= cand;
                        last_q   <= cand;
                        hist_vld <= 1'b1;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end else if (tries == LAST_TRY) begin
                        target   <= fallback;
                        last_q   <= fallback;
                        hist_vld <= 1'b1;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        tries <= tries + TRY_ONE;
                    end
                end
                HOLD: begin
                    // A req arriving together with ack is dropped on purpose.
                    if (ack) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rand_target_sel.md
# rand_target_sel

Downstream consumer of the 13-bit free-running LFSR random word. On request, it draws a bounded target index in 0..NUM_TARGETS-1 by rejection sampling over successive LFSR values, with a bounded number of tries and a deterministic fallback. It presents the index to the game controller with a valid/ack handshake.

## Interface
- NUM_TARGETS, 12: number of selectable targets; 2 ≤ NUM_TARGETS ≤ 2^IDX_W, and 2^IDX_W ≤ 2·NUM_TARGETS.
- IDX_W, 4: index width.
- MAX_TRIES, 8: draw cycles before fallback; ≥ 1.
- clk in 1: single clock; all logic on posedge.
- rst in 1: reset, synchronous, active-high.
- random in 13: LFSR word; changes every clock; sampled bits random[IDX_W-1:0].
- req in 1: draw request; sampled only in IDLE.
- ack in 1: consumer accepts target; sampled only in HOLD.
- busy out 1: high in DRAW and HOLD.
- valid out 1: target is valid; high only in HOLD.
- target out IDX_W: selected index; stable while valid.

## Operation
- States: IDLE, DRAW, HOLD.
- IDLE: on req, go to DRAW and clear tries. Otherwise stay.
- DRAW:
  - Candidate c = random[IDX_W-1:0] for the current cycle.
  - Accept when c < NUM_TARGETS and, if no-repeat is enabled and history is valid, c != last.
  - On accept: target <= c, last <= c, history valid <= 1, go to HOLD.
  - On reject with tries < MAX_TRIES-1: tries++ and stay in DRAW.
  - On reject with tries == MAX_TRIES-1: load the fallback F (see Configuration) into target and last, set history valid, go to HOLD.
- HOLD: valid = 1. On ack, go to IDLE. req is ignored.
- The tries counter is ceil(log2(MAX_TRIES))+1 bits and never wraps.
- Reset state:
  - state IDLE, tries 0.
  - valid 0, busy 0, target 0.
  - last 0, history valid 0, so the first draw after reset has no exclusion.
- Reset mid-DRAW or mid-HOLD aborts the draw. No valid pulse is produced and the history is cleared.
- ack in the same cycle as req while in HOLD: the ack is honoured and the req is dropped. The consumer must reassert req in IDLE.
- ack and req outside their sampling states have no effect.

## Timing
- Outputs are registered, with no combinational path from inputs to outputs.
- If req is high at edge E0, busy is high after E0.
- When the first DRAW cycle accepts, target and valid are visible after E1. This is the minimum latency of 2 edges from req.
- Worst case: valid after edge E(MAX_TRIES).
- valid stays high until the edge that samples ack. Both valid and busy are low after that edge.
- Back-to-back draws take at least 3 cycles per target: req, DRAW, HOLD with ack.

## Configuration
- Macro: RAND_TARGET_NO_REPEAT_EN.
- Defined:
  - Accept rule excludes c == last.
  - Fallback F = (last+1) mod NUM_TARGETS when history is valid, else 0.
  - Consecutive targets always differ.
- Undefined:
  - No exclusion and no comparator on last.
  - Fallback F = c − NUM_TARGETS, using the final rejected candidate. This is always in range by the width constraint.
  - Repeats are allowed.

## Structure
- Package rand_target_pkg holds:
  - the state enum (IDLE, DRAW, HOLD);
  - default constants TARGETS_DEFAULT=12, IDX_W_DEFAULT=4, TRIES_DEFAULT=8;
  - the LFSR_W=13 constant.
- One sub-module, rand_target_accept: purely combinational accept and fallback computation from c, last and history valid. The macro is resolved inside it.
- The FSM, counter and registers live in the top module.

## Test plan
- Reset: hold rst for 2 cycles with req=1 → valid=0, busy=0, target=0; no draw starts until rst falls.
- Direct accept: random=13'h0005 held, pulse req → valid after 2 edges with target=5; ack → valid=0, busy=0 on the next edge.
- Rejection: NUM_TARGETS=12, low nibble sequence 14, 15, 13, 3 → valid after 5 edges from req, target=3.
- No-repeat fallback (macro on): last=5, low nibble fixed at 5 → after 8 DRAW cycles, target=6.
  - Repeat with last=11 and nibble fixed at 11 → target=0 (wrap).
  - Macro off, nibble fixed at 14 → target=2.
- Reset mid-operation: assert rst on the 3rd DRAW cycle → IDLE, valid never rises; the next draw with nibble=last is accepted immediately.
- Handshake: req held through HOLD is ignored; ack and req in the same cycle → IDLE with no new draw; req in the next cycle starts a draw.
